// File: rtl/seq_multiplier_n_bits_pkg.sv
// Shared definitions for the buffered shift-and-add multiplier and its display wrappers.
package seq_multiplier_n_bits_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Product width for an N-bit operand multiplier.
  function automatic int prod_width(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/seq_multiplier_n_bits_if.sv
// Operand bus, control strobes and result/status signals of the buffered multiplier.
interface seq_multiplier_n_bits_if
  import seq_multiplier_n_bits_pkg::*;
#(
  parameter int N = 8
);

  localparam int PW = prod_width(N);

  logic [N-1:0]  data_in;
  logic          load_a;
  logic          load_b;
  logic          start;
  logic          signed_mode;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [PW-1:0] product;
  logic          busy;
  logic          done;

  modport master (
    output data_in, load_a, load_b, start, signed_mode,
    input  op_a, op_b, product, busy, done
  );

  modport slave (
    input  data_in, load_a, load_b, start, signed_mode,
    output op_a, op_b, product, busy, done
  );

endinterface

// File: rtl/seq_multiplier_n_bits_shift_add_core.sv
// Unsigned N-iteration shift-and-add datapath; applies the final sign on the last iteration.
module seq_multiplier_n_bits_shift_add_core
  import seq_multiplier_n_bits_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N-1:0]             mcand,
  input  logic [N-1:0]             mplier,
  input  logic                     negate,
  output logic                     last_iter,
  output logic                     finished,
  output logic [prod_width(N)-1:0] result
);

  localparam int PW = prod_width(N);

  logic [PW-1:0] acc;
  logic [PW-1:0] acc_step;
  logic [N:0]    sum;
  logic [N-1:0]  mcand_q;
  logic [CW-1:0] cnt;
  logic          active;
  logic          negate_q;

  // Lower half of acc starts as the multiplier and drains out as the product grows in from the top.
  always_comb begin
    sum       = {1'b0, acc[PW-1:N]} + (acc[0] ? {1'b0, mcand_q} : '0);
    acc_step  = {sum, acc[N-1:1]};
    last_iter = active && (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      mcand_q  <= '0;
      cnt      <= '0;
      active   <= 1'b0;
      negate_q <= 1'b0;
      finished <= 1'b0;
      result   <= '0;
    end else begin
      finished <= 1'b0;
      if (start) begin
        acc      <= {{N{1'b0}}, mplier};
        mcand_q  <= mcand;
        negate_q <= negate;
        cnt      <= '0;
        active   <= 1'b1;
      end else if (active) begin
        acc <= acc_step;
        cnt <= cnt + CW'(1);
        if (last_iter) begin
          active   <= 1'b0;
          finished <= 1'b1;
          result   <= negate_q ? -acc_step : acc_step;
        end
      end
    end
  end

endmodule

// File: rtl/seq_multiplier_n_bits.sv
// Buffered N-bit multiplier: operand registers, sign handling and the IDLE/RUN/DONE sequencer.
module seq_multiplier_n_bits
  import seq_multiplier_n_bits_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  seq_multiplier_n_bits_if.slave  bus
);

  state_t       state;
  state_t       state_next;
  logic [N-1:0] op_a_q;
  logic [N-1:0] op_b_q;
  logic [N-1:0] mag_a;
  logic [N-1:0] mag_b;
  logic         negate;
  logic         accept;
  logic         last_iter;
  logic         finished;

  // Magnitudes come from the buffers as they were before this edge, so a same-cycle load only affects the next multiply.
  always_comb begin
    accept = (state == ST_IDLE) && bus.start;
    mag_a  = (bus.signed_mode && op_a_q[N-1]) ? -op_a_q : op_a_q;
    mag_b  = (bus.signed_mode && op_b_q[N-1]) ? -op_b_q : op_b_q;
    negate = bus.signed_mode && (op_a_q[N-1] ^ op_b_q[N-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (state == ST_IDLE) begin
      if (bus.load_a) op_a_q <= bus.data_in;
      if (bus.load_b) op_b_q <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) state_next = ST_RUN;
      ST_RUN: begin
        bus.busy = 1'b1;
        if (last_iter) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  seq_multiplier_n_bits_shift_add_core #(
    .N  (N),
    .CW (CW)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (accept),
    .mcand     (mag_a),
    .mplier    (mag_b),
    .negate    (negate),
    .last_iter (last_iter),
    .finished  (finished),
    .result    (bus.product)
  );

  assign bus.op_a = op_a_q;
  assign bus.op_b = op_b_q;
  assign bus.done = finished;

endmodule

// File: tb/tb_seq_multiplier_n_bits.sv
// Scoreboard bench for the N=8 and N=16 buffered multipliers.
module tb_seq_multiplier_n_bits;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_multiplier_n_bits_if #(.N(8))  bus8 ();
  seq_multiplier_n_bits_if #(.N(16)) bus16 ();

  seq_multiplier_n_bits #(.N(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  seq_multiplier_n_bits #(.N(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  int total = 0;
  int bad = 0;
  int done8_cnt = 0;
  int done16_cnt = 0;
  logic [63:0] q8[$];
  logic [63:0] q16[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference product from sign-extended operands, truncated to 2n bits.
  function automatic logic [63:0] model(input int n, input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa;
    longint sb;
    longint p;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[n-1]) sa = sa - (longint'(1) << n);
    if (s && b[n-1]) sb = sb - (longint'(1) << n);
    p = sa * sb;
    return 64'(p) & ((64'(1) << (2 * n)) - 64'(1));
  endfunction

  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      done8_cnt++;
      if (q8.size() == 0) checkOutput("dut8_unexpected_done", 64'(1), 64'(0));
      else checkOutput("dut8_product", 64'(bus8.product), q8.pop_front());
    end
  end

  always @(negedge clk) begin
    if (bus16.done === 1'b1) begin
      done16_cnt++;
      if (q16.size() == 0) checkOutput("dut16_unexpected_done", 64'(1), 64'(0));
      else checkOutput("dut16_product", 64'(bus16.product), q16.pop_front());
    end
  end

  task automatic clearInputs();
    bus8.data_in = '0;  bus8.load_a = 0;  bus8.load_b = 0;  bus8.start = 0;  bus8.signed_mode = 0;
    bus16.data_in = '0; bus16.load_a = 0; bus16.load_b = 0; bus16.start = 0; bus16.signed_mode = 0;
  endtask

  // Loads A then B, then raises start (left high for waitDone to drop); optionally queues the expected product.
  task automatic applyStimulus(input bit wide, input logic [15:0] a, input logic [15:0] b,
                               input bit s, input bit push);
    @(negedge clk);
    if (wide) begin bus16.data_in = a; bus16.load_a = 1; end
    else      begin bus8.data_in = a[7:0]; bus8.load_a = 1; end
    @(negedge clk);
    if (wide) begin bus16.load_a = 0; bus16.data_in = b; bus16.load_b = 1; end
    else      begin bus8.load_a = 0; bus8.data_in = b[7:0]; bus8.load_b = 1; end
    @(negedge clk);
    if (wide) begin bus16.load_b = 0; bus16.signed_mode = s; bus16.start = 1; end
    else      begin bus8.load_b = 0; bus8.signed_mode = s; bus8.start = 1; end
    if (push) begin
      if (wide) q16.push_back(model(16, 32'(a), 32'(b), s));
      else      q8.push_back(model(8, 32'(a), 32'(b), s));
    end
  endtask

  // Waits for done after the start edge; with disturb, tries a load and a second start mid-run.
  task automatic waitDone(input bit wide, input bit disturb);
    int n;
    int busy_cnt;
    bit seen;
    n = wide ? 16 : 8;
    busy_cnt = 0;
    seen = 0;
    for (int i = 1; i <= 4 * n && !seen; i++) begin
      @(negedge clk);
      if (wide) begin bus16.start = 0; bus16.load_a = 0; bus16.load_b = 0; end
      else      begin bus8.start = 0; bus8.load_a = 0; bus8.load_b = 0; end
      if (disturb && !wide) begin
        if (i == 2) begin bus8.data_in = 8'h55; bus8.load_a = 1; end
        if (i == 3) bus8.start = 1;
      end
      if ((wide ? bus16.busy : bus8.busy) === 1'b1) busy_cnt++;
      if ((wide ? bus16.done : bus8.done) === 1'b1) begin
        seen = 1;
        checkOutput("done_latency", 64'(i), 64'(n + 1));
      end
    end
    checkOutput("busy_cycles", 64'(busy_cnt), 64'(n));
    if (!seen) checkOutput("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    logic [15:0] ra;
    logic [15:0] rb;
    bit rs;

    reset = 1;
    clearInputs();
    repeat (3) @(negedge clk);
    reset = 0;
    checkOutput("rst_op_a", 64'(bus8.op_a), 64'(0));
    checkOutput("rst_op_b", 64'(bus8.op_b), 64'(0));
    checkOutput("rst_product", 64'(bus8.product), 64'(0));
    checkOutput("rst_busy", 64'(bus8.busy), 64'(0));
    checkOutput("rst_done", 64'(bus8.done), 64'(0));
    checkOutput("rst_product16", 64'(bus16.product), 64'(0));

    applyStimulus(0, 16'h0F, 16'h0F, 0, 1);
    waitDone(0, 0);
    checkOutput("op_a_0f", 64'(bus8.op_a), 64'h0F);
    checkOutput("op_b_0f", 64'(bus8.op_b), 64'h0F);
    repeat (3) @(negedge clk);
    checkOutput("product_held", 64'(bus8.product), 64'h00E1);

    applyStimulus(0, 16'hFF, 16'hFF, 0, 1); waitDone(0, 0);
    applyStimulus(0, 16'hFF, 16'hFF, 1, 1); waitDone(0, 0);
    applyStimulus(0, 16'h80, 16'h7F, 1, 1); waitDone(0, 0);
    checkOutput("signed_min_x_max", 64'(bus8.product), 64'hC080);
    applyStimulus(0, 16'h80, 16'h80, 1, 1); waitDone(0, 0);
    checkOutput("signed_min_sq", 64'(bus8.product), 64'h4000);

    // Loads and start during RUN, and start during DONE, must all be ignored.
    applyStimulus(0, 16'h21, 16'h03, 0, 1);
    d0 = done8_cnt;
    waitDone(0, 1);
    bus8.start = 1;
    @(negedge clk);
    checkOutput("done_cycle_start_ignored", 64'(bus8.busy), 64'(0));
    bus8.start = 0;
    repeat (3) @(negedge clk);
    checkOutput("single_done", 64'(done8_cnt - d0), 64'(1));
    checkOutput("op_a_unchanged", 64'(bus8.op_a), 64'h21);
    checkOutput("product_0x21x3", 64'(bus8.product), 64'h0063);

    @(negedge clk);
    bus8.data_in = 8'h33; bus8.load_a = 1; bus8.signed_mode = 0; bus8.start = 1;
    q8.push_back(model(8, 32'h21, 32'h03, 0));
    waitDone(0, 0);
    checkOutput("op_a_loaded_with_start", 64'(bus8.op_a), 64'h33);

    // Abort 0x12*0x34 with reset sampled on the fourth iteration edge.
    applyStimulus(0, 16'h12, 16'h34, 0, 0);
    d0 = done8_cnt;
    @(negedge clk);
    bus8.start = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    checkOutput("abort_busy", 64'(bus8.busy), 64'(0));
    checkOutput("abort_product", 64'(bus8.product), 64'(0));
    checkOutput("abort_done", 64'(bus8.done), 64'(0));
    repeat (12) @(negedge clk);
    checkOutput("abort_no_done", 64'(done8_cnt - d0), 64'(0));
    applyStimulus(0, 16'h12, 16'h34, 0, 1); waitDone(0, 0);
    checkOutput("product_after_abort", 64'(bus8.product), 64'h03A8);

    for (int k = 0; k < 4; k++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      applyStimulus(0, ra, rb, rs, 1);
      waitDone(0, 0);
    end

    applyStimulus(1, 16'hFFFF, 16'h0002, 0, 1); waitDone(1, 0);
    checkOutput("n16_unsigned", 64'(bus16.product), 64'h0001FFFE);
    applyStimulus(1, 16'hFFFF, 16'h0002, 1, 1); waitDone(1, 0);
    checkOutput("n16_signed", 64'(bus16.product), 64'hFFFFFFFE);
    applyStimulus(1, 16'h8000, 16'h8000, 1, 1); waitDone(1, 0);

    repeat (3) @(negedge clk);
    checkOutput("q8_drained", 64'(q8.size()), 64'(0));
    checkOutput("q16_drained", 64'(q16.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
